knn_dist_col: RTL
=================

// Module: knn_dist_col
// PURPOSE
//  Pipelined distance column for the kNN array: stores one reference vector plus its label
//  and streams query vectors through a VECT_LEN-stage accumulation pipeline, one element per stage.
//  Emits per-query distance and label with valid/ready flow control.
//  Registered query pass-through feeds the next column in the array.
// PARAMETERS
//  VECT_LEN  4   elements per vector (>=1); also pipeline depth
//  WORD_LEN  6   bits per unsigned element
//  SUM_LEN   10  distance width; accumulation saturates
//  LBL_LEN   10  label width
// PORTS
//  clk        in   1                  clock, all state on posedge
//  rst_n      in   1                  async active-low reset
//  ld_en      in   1                  load request for reference vector + label
//  ld_vec     in   VECT_LEN*WORD_LEN  reference vector, element i at [i*WORD_LEN +: WORD_LEN]
//  ld_lbl     in   LBL_LEN            reference label
//  ld_ack     out  1                  1-cycle pulse: load accepted on previous edge
//  loaded     out  1                  reference valid since last reset
//  metric_sel in   1                  0=L1 (sum |d|), 1=L2 (sum d^2); sampled with the query
//  in_valid   in   1                  query valid
//  in_ready   out  1                  column can accept a query this cycle
//  in_vec     in   VECT_LEN*WORD_LEN  query vector, same packing as ld_vec
//  pass_valid out  1                  registered copy of accepted query is valid
//  pass_vec   out  VECT_LEN*WORD_LEN  query copy for the downstream column
//  out_valid  out  1                  distance result valid
//  out_ready  in   1                  consumer accepts result
//  out_sum    out  SUM_LEN            distance (saturated)
//  out_lbl    out  LBL_LEN            stored label accompanying the result
// BEHAVIOUR
//  Reset: ref regs, label, loaded, ld_ack, pass_valid, out_valid, all stage valids and sums = 0.
//  Query accepted on the edge where in_valid && in_ready.
//  in_ready = loaded && !stall && !ld_en.
//  stall = out_valid && !out_ready; stall freezes all stages, pass regs and out regs.
//  Load: accepted when ld_en && pipeline empty (no stage valid, out_valid=0).
//    Ref/label captured; loaded<=1; ld_ack pulses next cycle.
//    ld_en while not empty has no effect and no ld_ack; requester holds ld_en until acked.
//  Pipeline: stage k (0..VECT_LEN-1) carries valid, metric, full query, partial sum.
//    Stage k adds term(q[k], r[k]), where d = |q[k]-r[k]| (WORD_LEN-bit unsigned).
//    term = d for L1, d*d (2*WORD_LEN bits) for L2.
//    Stage 0 starts from sum 0. Sum add saturates to 2^SUM_LEN-1; a saturated sum stays saturated.
//  Latency: accept at edge E -> out_valid high after edge E+VECT_LEN, absent stall.
//    Throughput 1 query/cycle.
//  out_sum/out_lbl hold while out_valid && !out_ready.
//  out_valid drops after the handshake edge unless a new result arrives on the same edge.
//  pass_valid/pass_vec: updated on every non-stalled edge with (accept, in_vec).
//    One cycle after accept; independent of out_ready except through stall.
//  Simultaneous ld_en and in_valid: the load wins; in_ready=0 that cycle.
//  rst_n low mid-operation: all in-flight queries are discarded immediately (async).
//    loaded clears; a fresh load is required before any query.
// CONFIGURATION
//  KNN_DIST_L2_EN defined: metric_sel honoured; L2 squared-difference datapath built.
//  KNN_DIST_L2_EN undefined: metric_sel ignored, always L1, no multipliers synthesised.
//    Port list identical in both builds.
// TESTING
//  T1 reset -> all outputs 0, in_ready=0; ld_vec={1,2,3,4}, lbl=5 -> ld_ack 1 cycle later, loaded=1.
//  T2 ref {1,2,3,4}, query {4,2,0,9}, L1, out_ready=1 -> out_sum=11, out_lbl=5, VECT_LEN cycles after accept.
//  T3 back-to-back 8 queries, out_ready=1 -> 8 consecutive out_valid cycles, in order, no gaps.
//     pass_vec matches each query 1 cycle after its accept.
//  T4 out_ready=0 for 5 cycles while pipe full -> in_ready=0, out_sum held.
//     Release -> no loss or duplication.
//  T5 ref all 0, query all 63, L1 (sum 252), SUM_LEN=7 -> out_sum=127 (saturated).
//  T6 KNN_DIST_L2_EN: ref {1,2,3,4}, query {4,2,0,9}, metric_sel=1 -> out_sum=43.
//     Same query without macro -> 11.
//     ld_en during busy pipe -> no ld_ack until drained.

Source files
------------

// File: rtl/knn_dist_col.sv
// knn_dist_col: one distance column of the kNN array.
// It holds one reference vector and its label. Each query passes through a
// VECT_LEN-stage accumulate pipeline, one element per stage. The result is
// a saturated L1 or L2 distance. Each accepted query is also re-registered
// so it can feed the next column.
// Build option: define KNN_DIST_L2_EN to honour metric_sel (squared-difference
// datapath); otherwise the column is L1-only and no multipliers are built.

// Per-stage datapath: |q-r| (or its square), added into the running sum with saturation.
module knn_dist_term #(
  parameter int WORD_LEN = 6,
  parameter int SUM_LEN  = 10
) (
  input  logic [WORD_LEN-1:0] q,
  input  logic [WORD_LEN-1:0] r,
  input  logic                metric,
  input  logic [SUM_LEN-1:0]  sum_in,
  output logic [SUM_LEN-1:0]  sum_out
);
  localparam int TW = 2*WORD_LEN;
  // One spare bit above the wider operand so the add cannot wrap before the clamp.
  localparam int AW = ((SUM_LEN > TW) ? SUM_LEN : TW) + 1;
  localparam logic [AW-1:0] SAT = {{(AW-SUM_LEN){1'b0}}, {SUM_LEN{1'b1}}};

  logic [WORD_LEN-1:0] d;
  logic [TW-1:0]       dw;
  logic [TW-1:0]       term;
  logic [AW-1:0]       acc;

`ifndef KNN_DIST_L2_EN
  logic unused_metric;
  assign unused_metric = metric;
`endif

  // Absolute difference, selected term, then a clamped add (a saturated sum stays saturated).
  always_comb begin
    d  = (q >= r) ? (q - r) : (r - q);
    dw = {{WORD_LEN{1'b0}}, d};
`ifdef KNN_DIST_L2_EN
    term = metric ? (dw * dw) : dw;
`else
    term = dw;
`endif
    acc     = AW'(sum_in) + AW'(term);
    sum_out = (acc > SAT) ? {SUM_LEN{1'b1}} : acc[SUM_LEN-1:0];
  end
endmodule

module knn_dist_col #(
  parameter int VECT_LEN = 4,
  parameter int WORD_LEN = 6,
  parameter int SUM_LEN  = 10,
  parameter int LBL_LEN  = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ld_en,
  input  logic [VECT_LEN*WORD_LEN-1:0] ld_vec,
  input  logic [LBL_LEN-1:0]           ld_lbl,
  output logic                         ld_ack,
  output logic                         loaded,
  input  logic                         metric_sel,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [VECT_LEN*WORD_LEN-1:0] in_vec,
  output logic                         pass_valid,
  output logic [VECT_LEN*WORD_LEN-1:0] pass_vec,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SUM_LEN-1:0]           out_sum,
  output logic [LBL_LEN-1:0]           out_lbl
);
  localparam int VEC_W = VECT_LEN*WORD_LEN;

  logic [VEC_W-1:0]                 ref_vec;
  logic [LBL_LEN-1:0]               lbl;
  // vld_pipe[k] = stage k valid for k < VECT_LEN; vld_pipe[VECT_LEN] is the output register.
  logic [VECT_LEN:0]                vld_pipe;
  logic [VECT_LEN-1:0]              met_pipe;
  logic [VECT_LEN-1:0][VEC_W-1:0]   qry_pipe;
  logic [VECT_LEN:0][SUM_LEN-1:0]   sum_pipe;
  logic [VECT_LEN-1:0][SUM_LEN-1:0] sum_nxt;
  logic                             stall;
  logic                             empty;
  logic                             ld_go;
  logic                             accept;

  // A pending load blocks queries so the pipeline can drain before the reference changes.
  assign stall     = vld_pipe[VECT_LEN] && !out_ready;
  assign empty     = ~|vld_pipe;
  assign ld_go     = ld_en && empty;
  assign in_ready  = loaded && !stall && !ld_en;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_pipe[VECT_LEN];
  assign out_sum   = sum_pipe[VECT_LEN];
  assign out_lbl   = lbl;

  // Each stage reads only its own element; the query is still carried whole.
  logic unused_bits;
  assign unused_bits = ^{qry_pipe, met_pipe[VECT_LEN-1]};

  for (genvar k = 0; k < VECT_LEN; k++) begin : g_stage
    logic [WORD_LEN-1:0] q_k;
    logic                m_k;
    logic [SUM_LEN-1:0]  s_k;
    logic [SUM_LEN-1:0]  s_out;
    if (k == 0) begin : g_head
      assign q_k = in_vec[0 +: WORD_LEN];
      assign m_k = metric_sel;
      assign s_k = '0;
    end else begin : g_body
      assign q_k = qry_pipe[k-1][k*WORD_LEN +: WORD_LEN];
      assign m_k = met_pipe[k-1];
      assign s_k = sum_pipe[k-1];
    end
    knn_dist_term #(.WORD_LEN(WORD_LEN), .SUM_LEN(SUM_LEN)) u_term (
      .q(q_k), .r(ref_vec[k*WORD_LEN +: WORD_LEN]), .metric(m_k),
      .sum_in(s_k), .sum_out(s_out)
    );
    assign sum_nxt[k] = s_out;
  end

  // Reference/label capture; a load only lands while the pipeline is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_vec <= '0;
      lbl     <= '0;
      loaded  <= 1'b0;
      ld_ack  <= 1'b0;
    end else begin
      ld_ack <= ld_go;
      if (ld_go) begin
        ref_vec <= ld_vec;
        lbl     <= ld_lbl;
        loaded  <= 1'b1;
      end
    end
  end

  // Accumulate pipeline, output register and pass-through; all of them freeze together while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      met_pipe   <= '0;
      qry_pipe   <= '0;
      sum_pipe   <= '0;
      pass_valid <= 1'b0;
      pass_vec   <= '0;
    end else if (!stall) begin
      vld_pipe    <= {vld_pipe[VECT_LEN-1:0], accept};
      met_pipe[0] <= metric_sel;
      qry_pipe[0] <= in_vec;
      for (int k = 1; k < VECT_LEN; k++) begin
        met_pipe[k] <= met_pipe[k-1];
        qry_pipe[k] <= qry_pipe[k-1];
      end
      sum_pipe[VECT_LEN-1:0] <= sum_nxt;
      sum_pipe[VECT_LEN]     <= sum_pipe[VECT_LEN-1];
      pass_valid <= accept;
      pass_vec   <= in_vec;
    end
  end
endmodule
